// File: rtl/accel_core_ctrl.sv
// accel_core_ctrl: run controller for the DNN accelerator core.
// It decodes the control bits, sequences one engine/accumulator run, checks
// the per-kernel psum counts against the configured output size, enforces a
// watchdog, and reports sticky status, a run cycle count and a level interrupt.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no run in progress, waiting for a start edge
// RUN    | engine is issuing; psums and cycles are being counted
// DRAIN  | engine finished, waiting for the accumulator write-back
// DONE   | run finished with every kernel count matching (sticky)
// ERR    | run aborted by timeout, overrun or count mismatch (sticky)

module accel_core_ctrl #(
   parameter int NUM_KERNEL = 4,
   parameter int REG_WIDTH  = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_WIDTH-1:0]  i_conf_ctrl,
   input  logic [REG_WIDTH-1:0]  i_conf_outputsize,
   input  logic [REG_WIDTH-1:0]  i_conf_timeout,
   input  logic                  i_engine_done,
   input  logic                  i_accum_done,
   input  logic [NUM_KERNEL-1:0] i_psum_vld,
   output logic                  o_core_rst,
   output logic                  o_start,
   output logic [REG_WIDTH-1:0]  o_conf_status,
   output logic [REG_WIDTH-1:0]  o_cycle_count,
   output logic                  o_irq
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RUN   = 3'd1,
      S_DRAIN = 3'd2,
      S_DONE  = 3'd3,
      S_ERR   = 3'd4
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;

   logic                  r_start_q;
   logic                  r_clear_q;
   logic                  r_start;
   logic                  r_core_rst;
   logic                  r_accum_seen;
   logic                  r_flag_timeout;
   logic                  r_flag_mismatch;
   logic                  r_flag_overrun;
   logic [REG_WIDTH-1:0]  r_cycle_cnt;
   logic [CNT_WIDTH-1:0]  r_psum_cnt [NUM_KERNEL];

   logic                  w_start_edge;
   logic                  w_clear_edge;
   logic                  w_soft_rst;
   logic                  w_busy;
   logic [CNT_WIDTH-1:0]  w_outsize;
   logic [NUM_KERNEL-1:0] w_cnt_eq;
   logic                  w_overrun;
   logic                  w_timeout_hit;
   logic                  w_accum_seen;
   logic                  w_launch;
   logic                  w_clear;
   logic                  w_set_timeout;
   logic                  w_set_mismatch;
   logic                  w_set_overrun;
   logic [REG_WIDTH-1:0]  w_status;
   logic                  w_unused;

   assign w_start_edge = i_conf_ctrl[0] & ~r_start_q;
   assign w_clear_edge = i_conf_ctrl[3] & ~r_clear_q;
   assign w_soft_rst   = i_conf_ctrl[1];
   assign w_busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
   assign w_outsize    = i_conf_outputsize[CNT_WIDTH-1:0];
   assign w_accum_seen = i_accum_done | r_accum_seen;
   assign w_unused     = ^{i_conf_ctrl[REG_WIDTH-1:4], i_conf_ctrl[2],
                           i_conf_outputsize[REG_WIDTH-1:CNT_WIDTH]};

   // per-kernel "count already at target" compare
   always_comb begin
      w_cnt_eq = '0;
      for (int k = 0; k < NUM_KERNEL; k++) begin
         w_cnt_eq[k] = (r_psum_cnt[k] == w_outsize);
      end
   end

   assign w_overrun     = w_busy && ((i_psum_vld & w_cnt_eq) != '0);
   assign w_timeout_hit = w_busy && (i_conf_timeout != '0) &&
                          (r_cycle_cnt >= (i_conf_timeout - REG_WIDTH'(1)));

   // state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // next-state decode and flag-set strobes; soft reset > timeout > overrun > normal
   always_comb begin
      w_state_nxt    = r_state;
      w_launch       = 1'b0;
      w_clear        = 1'b0;
      w_set_timeout  = 1'b0;
      w_set_mismatch = 1'b0;
      w_set_overrun  = 1'b0;
      if (w_soft_rst) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start_edge) w_launch = 1'b1;
            end
            S_RUN: begin
               if (w_timeout_hit) begin
                  w_state_nxt   = S_ERR;
                  w_set_timeout = 1'b1;
               end else if (w_overrun) begin
                  w_state_nxt   = S_ERR;
                  w_set_overrun = 1'b1;
               end else if (i_engine_done) begin
                  w_state_nxt = S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (w_timeout_hit) begin
                  w_state_nxt   = S_ERR;
                  w_set_timeout = 1'b1;
               end else if (w_overrun) begin
                  w_state_nxt   = S_ERR;
                  w_set_overrun = 1'b1;
               end else if (w_accum_seen) begin
                  if (&w_cnt_eq) begin
                     w_state_nxt = S_DONE;
                  end else begin
                     w_state_nxt    = S_ERR;
                     w_set_mismatch = 1'b1;
                  end
               end
            end
            S_DONE, S_ERR: begin
               // start beats clear when both edges land together
               if (w_start_edge) begin
                  w_launch = 1'b1;
               end else if (w_clear_edge) begin
                  w_state_nxt = S_IDLE;
                  w_clear     = 1'b1;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
         if (w_launch) w_state_nxt = S_RUN;
      end
   end

   // control-bit history for edge detection, launch pulse and core reset
   always_ff @(posedge clk) begin
      r_core_rst <= rst | i_conf_ctrl[1];
      if (rst) begin
         r_start_q <= 1'b0;
         r_clear_q <= 1'b0;
         r_start   <= 1'b0;
      end else begin
         r_start_q <= i_conf_ctrl[0];
         r_clear_q <= i_conf_ctrl[3];
         r_start   <= w_launch;
      end
   end

   // sticky error flags and the accumulator-done latch
   always_ff @(posedge clk) begin
      if (rst || w_soft_rst || w_launch || w_clear) begin
         r_flag_timeout  <= 1'b0;
         r_flag_mismatch <= 1'b0;
         r_flag_overrun  <= 1'b0;
         r_accum_seen    <= 1'b0;
      end else begin
         r_flag_timeout  <= r_flag_timeout  | w_set_timeout;
         r_flag_mismatch <= r_flag_mismatch | w_set_mismatch;
         r_flag_overrun  <= r_flag_overrun  | w_set_overrun;
         r_accum_seen    <= r_accum_seen | (w_busy & i_accum_done);
      end
   end

   // saturating run cycle counter
   always_ff @(posedge clk) begin
      if (rst || w_soft_rst || w_launch)    r_cycle_cnt <= '0;
      else if (w_busy && !(&r_cycle_cnt))   r_cycle_cnt <= r_cycle_cnt + REG_WIDTH'(1);
   end

   // saturating per-kernel psum counters
   always_ff @(posedge clk) begin
      for (int k = 0; k < NUM_KERNEL; k++) begin
         if (rst || w_soft_rst || w_launch) begin
            r_psum_cnt[k] <= '0;
         end else if (w_busy && i_psum_vld[k] && !(&r_psum_cnt[k])) begin
            r_psum_cnt[k] <= r_psum_cnt[k] + CNT_WIDTH'(1);
         end
      end
   end

   // status word; the idle bit means "quiescent and healthy", so DONE reports it but ERR does not
   always_comb begin
      w_status    = '0;
      w_status[0] = (r_state == S_IDLE) || (r_state == S_DONE);
      w_status[1] = w_busy;
      w_status[2] = (r_state == S_DONE);
      w_status[3] = (r_state == S_ERR);
      w_status[4] = r_flag_timeout;
      w_status[5] = r_flag_mismatch;
      w_status[6] = r_flag_overrun;
      for (int k = 0; k < NUM_KERNEL; k++) begin
         w_status[8+k] = (r_state == S_ERR) && !w_cnt_eq[k];
      end
   end

   assign o_core_rst    = r_core_rst;
   assign o_start       = r_start;
   assign o_conf_status = w_status;
   assign o_cycle_count = r_cycle_cnt;
   assign o_irq         = i_conf_ctrl[2] & ((r_state == S_DONE) || (r_state == S_ERR));

endmodule

// File: tb/tb_accel_core_ctrl.sv
// Directed bench for accel_core_ctrl with hand-computed expected values.
module tb_accel_core_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ctrl;
   logic [31:0] osz;
   logic [31:0] tmo;
   logic        eng;
   logic        acc;
   logic [3:0]  vld;
   logic        o_core_rst;
   logic        o_start;
   logic [31:0] o_conf_status;
   logic [31:0] o_cycle_count;
   logic        o_irq;

   int n_tests = 0;
   int n_fail  = 0;

   accel_core_ctrl #(.NUM_KERNEL(4), .REG_WIDTH(32), .CNT_WIDTH(16)) dut (
      .clk               (clk),
      .rst               (rst),
      .i_conf_ctrl       (ctrl),
      .i_conf_outputsize (osz),
      .i_conf_timeout    (tmo),
      .i_engine_done     (eng),
      .i_accum_done      (acc),
      .i_psum_vld        (vld),
      .o_core_rst        (o_core_rst),
      .o_start           (o_start),
      .o_conf_status     (o_conf_status),
      .o_cycle_count     (o_cycle_count),
      .o_irq             (o_irq)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // four valids on every lane, then engine done, then accumulator done
   task automatic run_ok();
      vld = 4'hF;
      repeat (4) step();
      vld = 4'h0;
      eng = 1'b1;
      step();
      eng = 1'b0;
      acc = 1'b1;
      step();
      acc = 1'b0;
   endtask

   initial begin
      rst = 1'b1; ctrl = '0; osz = '0; tmo = '0; eng = 1'b0; acc = 1'b0; vld = '0;
      step(); step();
      check("rst_core_rst", {31'd0, o_core_rst}, 32'd1);
      check("rst_start",    {31'd0, o_start},    32'd0);
      check("rst_status",   o_conf_status,       32'h1);
      check("rst_count",    o_cycle_count,       32'd0);
      check("rst_irq",      {31'd0, o_irq},      32'd0);
      rst = 1'b0;
      step();
      check("rel_core_rst", {31'd0, o_core_rst}, 32'd0);

      // normal run
      osz = 32'd4;
      ctrl = 32'h1;
      step();
      check("t1_start",     {31'd0, o_start}, 32'd1);
      check("t1_busy",      o_conf_status,    32'h2);
      check("t1_count0",    o_cycle_count,    32'd0);
      vld = 4'hF;
      step();
      check("t1_start_off", {31'd0, o_start}, 32'd0);
      check("t1_count1",    o_cycle_count,    32'd1);
      step(); step(); step();
      vld = 4'h0;
      eng = 1'b1; step(); eng = 1'b0;
      acc = 1'b1; step(); acc = 1'b0;
      check("t1_done",      o_conf_status,    32'h5);
      check("t1_irq_off",   {31'd0, o_irq},   32'd0);
      check("t1_count",     o_cycle_count,    32'd6);
      ctrl = 32'h5;
      #1;
      check("t1_irq_on",    {31'd0, o_irq},   32'd1);

      // kernel 2 short one psum; accum_done arrives early in RUN and is latched
      ctrl = 32'h0; step();
      ctrl = 32'h1; step();
      check("t2_start", {31'd0, o_start}, 32'd1);
      vld = 4'hF; step(); step(); step();
      vld = 4'hB; step();
      vld = 4'h0;
      eng = 1'b1; acc = 1'b1; step();
      eng = 1'b0; acc = 1'b0;
      check("t2_drain",    o_conf_status,  32'h2);
      step();
      check("t2_mismatch", o_conf_status,  32'h428);
      check("t2_irq_off",  {31'd0, o_irq}, 32'd0);

      // watchdog with engine never finishing
      ctrl = 32'h0; tmo = 32'd10; step();
      ctrl = 32'h1; step();
      check("t3_count0", o_cycle_count, 32'd0);
      repeat (9) step();
      check("t3_busy9",  o_conf_status, 32'h2);
      check("t3_count9", o_cycle_count, 32'd9);
      step();
      check("t3_timeout", o_conf_status, 32'hF18);
      check("t3_count10", o_cycle_count, 32'd10);
      step();
      check("t3_hold",    o_cycle_count, 32'd10);

      // kernel 0 overrun on its fifth valid; later valids ignored
      tmo = 32'd0; ctrl = 32'h0; step();
      ctrl = 32'h1; step();
      vld = 4'hF; repeat (4) step();
      vld = 4'h1; step();
      check("t4_overrun", o_conf_status, 32'h148);
      vld = 4'hF; step();
      vld = 4'h0;
      check("t4_ignored", o_conf_status, 32'h148);
      check("t4_count",   o_cycle_count, 32'd5);

      // clear from DONE
      ctrl = 32'h0; step();
      ctrl = 32'h1; step();
      run_ok();
      check("t5_done", o_conf_status, 32'h5);
      ctrl = 32'h5; #1;
      check("t5_irq_on", {31'd0, o_irq}, 32'd1);
      ctrl = 32'hD; step();
      check("t5_cleared",  o_conf_status,  32'h1);
      check("t5_irq_off",  {31'd0, o_irq}, 32'd0);

      // start and clear together from DONE: start wins
      ctrl = 32'h0; step();
      ctrl = 32'h1; step();
      run_ok();
      check("t5_done2", o_conf_status, 32'h5);
      ctrl = 32'h0; step();
      ctrl = 32'h9; step();
      check("t5_both_start", {31'd0, o_start}, 32'd1);
      check("t5_both_busy",  o_conf_status,    32'h2);

      // soft reset mid-run
      vld = 4'hF; step(); step(); vld = 4'h0;
      check("t6_count2", o_cycle_count, 32'd2);
      ctrl = 32'h2; step();
      check("t6_core_rst", {31'd0, o_core_rst}, 32'd1);
      check("t6_status",   o_conf_status,       32'h1);
      check("t6_count",    o_cycle_count,       32'd0);
      ctrl = 32'h3; step();
      check("t6_no_start", {31'd0, o_start},    32'd0);
      check("t6_idle",     o_conf_status,       32'h1);
      ctrl = 32'h0; step();
      check("t6_core_rel", {31'd0, o_core_rst}, 32'd0);
      ctrl = 32'h1; step();
      check("t6_restart",  {31'd0, o_start},    32'd1);
      run_ok();
      check("t6_done",  o_conf_status, 32'h5);
      check("t6_count6", o_cycle_count, 32'd6);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
